// File: rtl/hw_sw_mailbox_pkg.sv
// Shared register map and STATUS layout for the hardware/software mailbox.
package hw_sw_pkg;

  localparam int unsigned CTRL_ADDR   = 32'd0;
  localparam int unsigned STATUS_ADDR = 32'd1;
  localparam int unsigned PORT_BASE   = 32'd2;

  localparam int unsigned ST_NE_LSB   = 32'd0;
  localparam int unsigned ST_OVF_LSB  = 32'd8;
  localparam int unsigned ST_MASK_LSB = 32'd16;
  localparam int unsigned ST_MASK_W   = 32'd8;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_CTRL   = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_PORT   = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/hw_sw_mailbox_if.sv
// Avalon-MM style register bus between the CPU side and the mailbox.
interface hw_sw_mailbox_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output chipselect, write, read, address, writedata, input readdata);
  modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/hw_sw_mailbox_meta_fifo.sv
// Per-port receive metadata FIFO; a pop frees the slot a same-cycle push may use.
module meta_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_pop_s;
  logic              do_push_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign overflow  = push & full & ~do_pop_s;
  assign head      = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end
endmodule

// File: rtl/hw_sw_mailbox.sv
// Register-mapped mailbox between switch ports and software.
// Optional HW_SW_MAILBOX_IRQ_EN adds a level interrupt output.
module hw_sw_mailbox
  import hw_sw_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  hw_sw_mailbox_if.slave              bus,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [NUM_PORTS-1:0]        out_en,
  output logic [DATA_W-1:0]           out_data,
  output logic [DATA_W-1:0]           ctrl
`ifdef HW_SW_MAILBOX_IRQ_EN
  ,
  output logic                        irq
`endif
);
  logic              rd_s;
  logic              wr_s;
  logic [ADDR_W-1:0] address_s;
  logic [31:0]       addr_s;
  reg_sel_e          sel_s;
  logic [NUM_PORTS-1:0] hit_s, pop_s, clr_s, empty_s, full_s, ovf_s;
  logic [NUM_PORTS-1:0] sticky_r;
  logic [DATA_W-1:0] head_s [NUM_PORTS];
  logic [DATA_W-1:0] status_s;
  logic [DATA_W-1:0] rd_next_s;
  logic [DATA_W-1:0] readdata_r;

  assign rd_s          = bus.chipselect & bus.read;
  assign wr_s          = bus.chipselect & bus.write;
  assign address_s     = bus.address;
  assign addr_s        = 32'(address_s);
  assign bus.readdata  = readdata_r;
  assign in_ready      = ~full_s;

  // Address decode and per-port pop / sticky-clear strobes.
  always_comb begin
    sel_s = SEL_NONE;
    if (addr_s == CTRL_ADDR) begin
      sel_s = SEL_CTRL;
    end else if (addr_s == STATUS_ADDR) begin
      sel_s = SEL_STATUS;
    end else if ((addr_s >= PORT_BASE) && (addr_s < PORT_BASE + 32'(NUM_PORTS))) begin
      sel_s = SEL_PORT;
    end else begin
      sel_s = SEL_NONE;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit_s[i] = (sel_s == SEL_PORT) && (addr_s == PORT_BASE + 32'(i));
      pop_s[i] = rd_s & hit_s[i] & ~empty_s[i];
      clr_s[i] = wr_s && (sel_s == SEL_STATUS) && bus.writedata[ST_OVF_LSB + 32'(i)];
    end
  end

  // STATUS image and read-data selection; an empty port reads as zero.
  always_comb begin
    status_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      status_s[ST_NE_LSB + 32'(i)]  = ~empty_s[i];
      status_s[ST_OVF_LSB + 32'(i)] = sticky_r[i];
    end
    status_s[ST_MASK_LSB +: ST_MASK_W] = ctrl[ST_MASK_W-1:0];
    rd_next_s = '0;
    if (rd_s) begin
      case (sel_s)
        SEL_CTRL:   rd_next_s = ctrl;
        SEL_STATUS: rd_next_s = status_s;
        SEL_PORT: begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            rd_next_s = rd_next_s | (head_s[i] & {DATA_W{pop_s[i]}});
          end
        end
        default:    rd_next_s = '0;
      endcase
    end else begin
      rd_next_s = '0;
    end
  end

  // Register file, read-data, write strobes and overflow stickies (a new overflow wins over W1C).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl       <= '0;
      readdata_r <= '0;
      out_en     <= '0;
      out_data   <= '0;
      sticky_r   <= '0;
    end else begin
      if (wr_s && (sel_s == SEL_CTRL)) ctrl <= bus.writedata;
      readdata_r <= rd_next_s;
      out_en     <= wr_s ? hit_s : '0;
      out_data   <= (wr_s && (sel_s == SEL_PORT)) ? bus.writedata : '0;
      sticky_r   <= (sticky_r & ~clr_s) | ovf_s;
    end
  end

`ifdef HW_SW_MAILBOX_IRQ_EN
  // Level interrupt from masked non-empty ports or any pending overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= (|(~empty_s & ctrl[NUM_PORTS-1:0])) | (|sticky_r);
    end
  end
`endif

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    meta_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (in_valid[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (pop_s[g]),
      .head      (head_s[g]),
      .empty     (empty_s[g]),
      .full      (full_s[g]),
      .overflow  (ovf_s[g])
    );
  end
endmodule

// File: tb/tb_hw_sw_mailbox.sv
// Self-checking bench for hw_sw_mailbox: vector table, corner sequences, random traffic vs queue model.
module tb_hw_sw_mailbox;
  localparam int NP = 4, DW = 32, DEPTH = 4, AW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hw_sw_mailbox_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [NP-1:0]    in_valid, in_ready, out_en;
  logic [NP*DW-1:0] in_data;
  logic [DW-1:0]    out_data, ctrl;
`ifdef HW_SW_MAILBOX_IRQ_EN
  logic irq;
`endif

  hw_sw_mailbox #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_en   (out_en),
    .out_data (out_data),
    .ctrl     (ctrl)
`ifdef HW_SW_MAILBOX_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: software-visible state kept as queues and flags.
  logic [DW-1:0] mq [NP][$];
  logic [DW-1:0] ctrl_m;
  logic [NP-1:0] sticky_m;
  logic [DW-1:0] exp_rdata, exp_od;
  logic [NP-1:0] exp_en;
  logic          exp_irq;

  typedef struct {
    bit          cs, wr, rd;
    int          addr;
    logic [31:0] wd, e_rd;
    logic [3:0]  e_en;
    logic [31:0] e_od, e_ctrl;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [NP*DW-1:0] slot(input int p, input logic [DW-1:0] v);
    return (NP*DW)'(v) << (p * DW);
  endfunction

  function automatic logic [DW-1:0] status_m();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < NP; i++) begin
      s[i]     = (mq[i].size() > 0);
      s[8 + i] = sticky_m[i];
    end
    s[23:16] = ctrl_m[7:0];
    return s;
  endfunction

  task automatic model_reset();
    ctrl_m = '0;
    sticky_m = '0;
    for (int i = 0; i < NP; i++) mq[i].delete();
  endtask

  task automatic model_cycle(input bit wr, input bit rd, input int addr, input logic [DW-1:0] wd,
                             input logic [NP-1:0] v, input logic [NP*DW-1:0] d);
    logic [NP-1:0] set = '0;
    exp_irq = (sticky_m != '0);
    for (int i = 0; i < NP; i++) if (mq[i].size() > 0 && ctrl_m[i]) exp_irq = 1'b1;
    exp_rdata = '0;
    if (rd) begin
      if (addr == 0) exp_rdata = ctrl_m;
      else if (addr == 1) exp_rdata = status_m();
      else if (addr >= 2 && addr < 2 + NP && mq[addr-2].size() > 0) exp_rdata = mq[addr-2].pop_front();
    end
    for (int i = 0; i < NP; i++) begin
      if (v[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d[i*DW +: DW]);
        else set[i] = 1'b1;
      end
    end
    if (wr && addr == 1) sticky_m = sticky_m & ~wd[8 +: NP];
    sticky_m = sticky_m | set;
    if (wr && addr == 0) ctrl_m = wd;
    exp_en = '0;
    exp_od = '0;
    if (wr && addr >= 2 && addr < 2 + NP) begin
      exp_en = NP'(1) << (addr - 2);
      exp_od = wd;
    end
  endtask

  task automatic step(input bit cs, input bit wr, input bit rd, input int addr, input logic [DW-1:0] wd,
                      input logic [NP-1:0] v, input logic [NP*DW-1:0] d);
    logic [NP-1:0] rdy;
    @(negedge clk);
    bus.chipselect = cs; bus.write = wr; bus.read = rd;
    bus.address = AW'(addr); bus.writedata = wd;
    in_valid = v; in_data = d;
    model_cycle(cs & wr, cs & rd, addr, wd, v, d);
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) rdy[i] = (mq[i].size() < DEPTH);
    chk("readdata", bus.readdata, exp_rdata);
    chk("out_en", DW'(out_en), DW'(exp_en));
    chk("out_data", out_data, exp_od);
    chk("ctrl", ctrl, ctrl_m);
    chk("in_ready", DW'(in_ready), DW'(rdy));
`ifdef HW_SW_MAILBOX_IRQ_EN
    chk("irq", DW'(irq), DW'(exp_irq));
`endif
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    in_valid = '0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, '0, '0, '0);
  endtask

  task automatic rd_op(input int addr);
    step(1'b1, 1'b0, 1'b1, addr, '0, '0, '0);
  endtask

  task automatic wr_op(input int addr, input logic [DW-1:0] wd);
    step(1'b1, 1'b1, 1'b0, addr, wd, '0, '0);
  endtask

  task automatic push(input int p, input logic [DW-1:0] v);
    step(1'b0, 1'b0, 1'b0, 0, '0, NP'(1) << p, slot(p, v));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 32'h0,        32'h0,         4'b0000, 32'h0,  32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 0, 32'h0000_00A3, 32'h0,        4'b0000, 32'h0,  32'hA3};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 0, 32'h0,        32'h0000_00A3, 4'b0000, 32'h0,  32'hA3};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1, 32'h0,        32'h00A3_0000, 4'b0000, 32'h0,  32'hA3};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 3, 32'h0000_00A5, 32'h0,        4'b0010, 32'hA5, 32'hA3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 0, 32'h0,        32'h0,         4'b0000, 32'h0,  32'hA3};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 7, 32'h0,        32'h0,         4'b0000, 32'h0,  32'hA3};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 9, 32'hFFFF_FFFF, 32'h0,        4'b0000, 32'h0,  32'hA3};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 0, 32'h0000_0055, 32'h0,        4'b0000, 32'h0,  32'hA3};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 2, 32'h0,        32'h0,         4'b0000, 32'h0,  32'hA3};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 0, 32'h0,        32'h0000_00A3, 4'b0000, 32'h0,  32'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1, 32'h0,        32'h0,         4'b0000, 32'h0,  32'h0};

    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    in_valid = '0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_out_en", DW'(out_en), 32'h0);
    chk("rst_ctrl", ctrl, 32'h0);
    chk("rst_in_ready", DW'(in_ready), 32'hF);

    for (int k = 0; k < 12; k++) begin
      step(vecs[k].cs, vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wd, '0, '0);
      chk($sformatf("vec%0d_rd", k), bus.readdata, vecs[k].e_rd);
      chk($sformatf("vec%0d_en", k), DW'(out_en), DW'(vecs[k].e_en));
      chk($sformatf("vec%0d_od", k), out_data, vecs[k].e_od);
      chk($sformatf("vec%0d_ctrl", k), ctrl, vecs[k].e_ctrl);
    end

    // Two entries on port 0 come back in order, then the port reads empty.
    push(0, 32'h11);
    push(0, 32'h22);
    rd_op(2); chk("p0_first", bus.readdata, 32'h11);
    rd_op(2); chk("p0_second", bus.readdata, 32'h22);
    rd_op(2); chk("p0_empty", bus.readdata, 32'h0);
    rd_op(1); chk("p0_status_ne", bus.readdata & 32'h1, 32'h0);

    // Overfill port 2, then clear its overflow sticky with W1C.
    for (int k = 0; k < 5; k++) begin
      push(2, 32'h200 + 32'(k));
      if (k == 3) chk("p2_ready_full", DW'(in_ready[2]), 32'h0);
    end
    rd_op(1); chk("p2_ovf_set", DW'(bus.readdata[10]), 32'h1);
    wr_op(1, 32'h400);
    rd_op(1); chk("p2_ovf_clr", DW'(bus.readdata[10]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      rd_op(4); chk("p2_drain", bus.readdata, 32'h200 + 32'(k));
    end

    // Full port 1 with simultaneous push and pop.
    for (int k = 0; k < 4; k++) push(1, 32'h101 + 32'(k));
    step(1'b1, 1'b0, 1'b1, 3, '0, 4'b0010, slot(1, 32'h77));
    chk("p1_oldest", bus.readdata, 32'h101);
    chk("p1_still_full", DW'(in_ready[1]), 32'h0);
    rd_op(1); chk("p1_no_ovf", DW'(bus.readdata[9]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      rd_op(3); chk("p1_order", bus.readdata, 32'h102 + 32'(k));
    end
    rd_op(3); chk("p1_last", bus.readdata, 32'h77);

    // Asynchronous reset with entries buffered.
    wr_op(0, 32'h3C);
    for (int k = 0; k < 3; k++) push(3, 32'h300 + 32'(k));
    step(1'b1, 1'b1, 1'b1, 0, 32'h5A, '0, '0);
    chk("pre_rst_rd", bus.readdata, 32'h3C);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_readdata", bus.readdata, 32'h0);
    chk("arst_ctrl", ctrl, 32'h0);
    chk("arst_out_en", DW'(out_en), 32'h0);
    chk("arst_out_data", out_data, 32'h0);
`ifdef HW_SW_MAILBOX_IRQ_EN
    chk("arst_irq", DW'(irq), 32'h0);
`endif
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rd_op(1); chk("post_rst_status", bus.readdata, 32'h0);
    rd_op(5); chk("post_rst_p3", bus.readdata, 32'h0);

`ifdef HW_SW_MAILBOX_IRQ_EN
    wr_op(0, 32'h1);
    push(0, 32'hABC); chk("irq_lag", DW'(irq), 32'h0);
    idle();           chk("irq_rise", DW'(irq), 32'h1);
    rd_op(2);         chk("irq_hold", DW'(irq), 32'h1);
    idle();           chk("irq_fall", DW'(irq), 32'h0);
`endif

    // Random traffic: heavy ingress first, then sparse ingress to drain.
    for (int n = 0; n < 600; n++) begin
      bit cs, wr, rd;
      int op;
      logic [NP-1:0] v;
      logic [NP*DW-1:0] d;
      cs = ($urandom_range(0, 9) != 0);
      op = $urandom_range(0, 9);
      rd = (op < 6);
      wr = (op >= 4);
      if (n < 300) v = NP'($urandom);
      else v = NP'($urandom & $urandom & $urandom & $urandom);
      for (int i = 0; i < NP; i++) d[i*DW +: DW] = $urandom;
      step(cs, wr, rd, $urandom_range(0, 7), $urandom, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hw_sw_mailbox.md
HW_SW_MAILBOX -- requirements
Module: hw_sw_mailbox

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of switch ports served (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, register and metadata width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, per-port receive metadata FIFO depth (power of 2, >=2).
REQ-004 SHALL have parameter ADDR_W, default 4, word address width; NUM_PORTS+2 <= 2**ADDR_W.
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have Avalon-MM slave ports chipselect/write/read (in, 1), address (in, ADDR_W), writedata (in, DATA_W), readdata (out, DATA_W).
REQ-008 SHALL have port in_valid  in  NUM_PORTS  per-port egress metadata valid.
REQ-009 SHALL have port in_data  in  NUM_PORTS*DATA_W  per-port metadata, port i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port in_ready  out  NUM_PORTS  per-port FIFO not full.
REQ-011 SHALL have port out_en  out  NUM_PORTS  one-cycle per-port software write strobe to ingress.
REQ-012 SHALL have port out_data  out  DATA_W  write payload qualified by out_en.
REQ-013 SHALL have port ctrl  out  DATA_W  control register contents.

Function
REQ-014 SHALL decode word address 0 = CTRL (RW), 1 = STATUS, 2+i = PORT i; all other addresses read 0 and ignore writes.
REQ-015 Write to CTRL SHALL update ctrl on the next edge.
REQ-016 Write to PORT i SHALL assert out_en[i] and drive out_data = writedata for exactly one cycle, next edge; otherwise out_en = 0 and out_data = 0.
REQ-017 Read SHALL return readdata one cycle after the accepted read; readdata = 0 in cycles without a read.
REQ-018 STATUS read SHALL return bit i = FIFO i non-empty, bit 8+i = overflow sticky i, bits [23:16] = ctrl[7:0] irq mask echo; unused bits 0.
REQ-019 STATUS write SHALL clear overflow sticky bits where writedata[8+i] = 1 (W1C).
REQ-020 PORT i read with FIFO i non-empty SHALL return the head entry and pop it in the same cycle.
REQ-021 PORT i read with FIFO i empty SHALL return 0 and leave the FIFO unchanged, even if a push occurs that cycle (no bypass).
REQ-022 in_valid[i] with FIFO i not full SHALL push in_data slice i; in_ready[i] = not full, combinational from count.
REQ-023 in_valid[i] while full and not popped that cycle SHALL drop the data and set overflow sticky i.
REQ-024 Simultaneous push and pop on a full FIFO SHALL accept the push; count unchanged, no overflow.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count width = clog2(FIFO_DEPTH)+1.
REQ-026 Simultaneous chipselect read and write SHALL perform both actions.

Reset
REQ-027 reset_n low SHALL asynchronously clear ctrl, readdata, out_en, out_data, all FIFO pointers/counts, overflow stickies and irq; FIFO storage need not clear.
REQ-028 Reset mid-operation SHALL discard all buffered metadata; first post-reset read of any port returns 0.

Configuration
REQ-029 With HW_SW_MAILBOX_IRQ_EN defined, SHALL add output irq (1 bit) = registered OR over i of (non-empty[i] AND ctrl[i]) OR any overflow sticky, level until cleared.
REQ-030 Without HW_SW_MAILBOX_IRQ_EN, irq port SHALL not exist; software polls STATUS.

Structure
REQ-031 Address constants (CTRL, STATUS, PORT_BASE) and STATUS bit offsets SHALL live in package hw_sw_pkg.
REQ-032 Per-port buffering SHALL be sub-module meta_fifo (params DATA_W, FIFO_DEPTH), instantiated NUM_PORTS times via generate.

Verification
REQ-033 Write 0xA5 to address 3 -> out_en = 4'b0010, out_data = 0xA5 for one cycle, then both 0.
REQ-034 Push 0x11, 0x22 on port 0; read address 2 twice -> readdata 0x11 then 0x22; third read -> 0, STATUS bit0 = 0.
REQ-035 Push 5 entries into port 2 (depth 4) -> in_ready[2] = 0 after 4th, STATUS bit 10 = 1; write STATUS 0x400 -> bit 10 clears.
REQ-036 Full port 1, same-cycle push 0x77 and read -> returns oldest entry, count stays 4, no overflow, 0x77 read last.
REQ-037 Pulse reset_n low mid-stream with 3 entries buffered -> all outputs 0 asynchronously, STATUS = 0, port reads return 0.
REQ-038 With HW_SW_MAILBOX_IRQ_EN, ctrl = 0x1, push on port 0 -> irq rises one cycle later; pop -> irq falls.
